io_perf_counters: RTL

- Memory-mapped performance-counter block for the Riscv151 core.
- Sits on the MMIO side of the data-memory path. It takes load/store requests that the address decoder routes to its window, and returns registered read data to the writeback mux.
- Counts cycles, retired instructions and pipeline stall cycles. A single store clears all counters, so assembly tests can measure code regions.

---
 rtl/io_perf_counters_pkg.sv | 23 ++
 rtl/io_perf_counters_perf_counter.sv | 29 ++
 rtl/io_perf_counters.sv | 111 +++++++++++
 3 files changed

// File: rtl/io_perf_counters_pkg.sv
`default_nettype none
// ============================================================================
// io_perf_counters_pkg : MMIO register map shared with decoder and asm tests
// Revision: 1.0
// ============================================================================
package io_perf_counters_pkg;

    localparam logic [31:0] PERF_BASE_ADDR = 32'h8000_0010;

    localparam logic [4:0] PERF_CYCLE_LO = 5'h00;
    localparam logic [4:0] PERF_CYCLE_HI = 5'h04;
    localparam logic [4:0] PERF_INSTRET  = 5'h08;
    localparam logic [4:0] PERF_STALLS   = 5'h0C;
    localparam logic [4:0] PERF_CLEAR    = 5'h10;

    localparam int PERF_NUM_WORDS = 5;

    function automatic logic [2:0] perf_word(input logic [4:0] off);
        return off[4:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_perf_counters_perf_counter.sv
`default_nettype none
// ============================================================================
// perf_counter : WIDTH-bit wrapping event counter, synchronous clear has priority
// Revision: 1.0
// ============================================================================
module perf_counter
    import io_perf_counters_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(inc);
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_perf_counters.sv
`default_nettype none
// ============================================================================
// io_perf_counters : MMIO cycle / instret / stall counters with registered reads
// Revision: 1.0
// ============================================================================
module io_perf_counters
    import io_perf_counters_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = PERF_BASE_ADDR,
    parameter int          CYCLE_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic        inst_retire,
    input  logic        stall,
    output logic [31:0] rdata,
    output logic        rvalid
);

    localparam logic [2:0] SEL_LO    = perf_word(PERF_CYCLE_LO);
    localparam logic [2:0] SEL_HI    = perf_word(PERF_CYCLE_HI);
    localparam logic [2:0] SEL_INST  = perf_word(PERF_INSTRET);
    localparam logic [2:0] SEL_STALL = perf_word(PERF_STALLS);
    localparam logic [2:0] SEL_CLEAR = perf_word(PERF_CLEAR);

    logic [29:0]            word_idx;
    logic                   hit;
    logic [2:0]             sel;
    logic                   rd_hit;
    logic                   rd_lo;
    logic                   clear;
    logic [CYCLE_WIDTH-1:0] cycle;
    logic [31:0]            cycle_hi;
    logic [31:0]            instret;
    logic [31:0]            stalls;
    logic [31:0]            hi_snap;
    logic [31:0]            read_mux;
    logic                   unused_bits;

    // Unsigned wrap makes addresses below the base land far outside the window.
    assign word_idx = addr[31:2] - BASE_ADDR[31:2];
    assign hit      = (word_idx < 30'(PERF_NUM_WORDS));
    assign sel      = word_idx[2:0];
    assign rd_hit   = re & hit;
    assign rd_lo    = rd_hit & (sel == SEL_LO);
    assign clear    = we & hit & (sel == SEL_CLEAR);
    assign cycle_hi = 32'(cycle >> 32);

    assign unused_bits = ^{wdata, addr[1:0]};

    perf_counter #(.WIDTH(CYCLE_WIDTH)) u_cycle (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (1'b1),
        .count (cycle)
    );

    perf_counter #(.WIDTH(32)) u_instret (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (inst_retire),
        .count (instret)
    );

    perf_counter #(.WIDTH(32)) u_stalls (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (stall),
        .count (stalls)
    );

    always_comb begin
        read_mux = '0;
        case (sel)
            SEL_LO:    read_mux = cycle[31:0];
            SEL_HI:    read_mux = hi_snap;
            SEL_INST:  read_mux = instret;
            SEL_STALL: read_mux = stalls;
            SEL_CLEAR: read_mux = '0;
            default:   read_mux = '0;
        endcase
    end

    // Reads return the pre-edge value, so a read alongside a clear sees old data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata   <= '0;
            rvalid  <= 1'b0;
            hi_snap <= '0;
        end else begin
            rvalid <= rd_hit;
            if (rd_hit) begin
                rdata <= read_mux;
            end
            if (clear) begin
                hi_snap <= '0;
            end else if (rd_lo) begin
                hi_snap <= cycle_hi;
            end
        end
    end

endmodule
`default_nettype wire
